// File: rtl/core_switch_pkg.sv
// Shared types for core_switch: FSM states, the per-core video/SD/LED bundle and its blanked value.
package core_switch_pkg;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
        logic       hs;
        logic       vs;
        logic       hblank;
        logic       vblank;
        logic       cepix;
        logic       sd_cs;
        logic       sd_mosi;
        logic       sd_sck;
        logic       drive_led;
    } video_bus_t;

    // Idle bundle: black, in blanking, SD bus parked deselected, LED off.
    localparam video_bus_t BLANK_BUS = '{
        r: 2'b00, g: 2'b00, b: 2'b00,
        hs: 1'b1, vs: 1'b1, hblank: 1'b1, vblank: 1'b1, cepix: 1'b0,
        sd_cs: 1'b1, sd_mosi: 1'b1, sd_sck: 1'b0, drive_led: 1'b0
    };

endpackage

// File: rtl/core_switch_if.sv
// Core-facing bus of core_switch: per-core bundles in, per-core enables/resets and muxed bundle out.
interface core_switch_if
    import core_switch_pkg::*;
#(
    parameter int unsigned NUM_CORES = 3
) ();

    video_bus_t [NUM_CORES-1:0] core_in;
    logic       [NUM_CORES-1:0] core_ce;
    logic       [NUM_CORES-1:0] core_n_reset;
    video_bus_t                 vid_out;

    modport master (output core_in, input core_ce, input core_n_reset, input vid_out);
    modport slave  (input core_in, output core_ce, output core_n_reset, output vid_out);

endinterface

// File: rtl/core_switch_mux.sv
// Registered NUM_CORES-to-1 bundle mux; when blanked it parks the outputs but keeps the last hs/vs.
module core_switch_mux
    import core_switch_pkg::*;
#(
    parameter int unsigned NUM_CORES = 3,
    parameter int unsigned SEL_W     = $clog2(NUM_CORES)
) (
    input  logic                       clk,
    input  logic                       n_reset,
    input  video_bus_t [NUM_CORES-1:0] core_in,
    input  logic       [SEL_W-1:0]     idx,
    input  logic                       blank,
    output video_bus_t                 vid_out
);

    video_bus_t cur_c;
    video_bus_t nxt_c;

    // Sync polarity stays continuous across blanking; cepix keeps the scaler clocked.
    always_comb begin
        cur_c = core_in[idx];
        nxt_c = cur_c;
        if (blank) begin
            nxt_c       = BLANK_BUS;
            nxt_c.hs    = vid_out.hs;
            nxt_c.vs    = vid_out.vs;
            nxt_c.cepix = cur_c.cepix;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) vid_out <= BLANK_BUS;
        else          vid_out <= nxt_c;
    end

endmodule

// File: rtl/core_switch.sv
// Sequenced run/reset/clock-enable owner for NUM_CORES cores with a registered output mux.
// Define CORE_SWITCH_VBLANK_SYNC_EN to align START/DRAIN to vblank (and SD idle) with a timeout.
module core_switch
    import core_switch_pkg::*;
#(
    parameter int unsigned NUM_CORES    = 3,
    parameter int unsigned SEL_W        = $clog2(NUM_CORES),
    parameter int unsigned RST_HOLD     = 16,
    parameter int unsigned SYNC_TIMEOUT = 2000000
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic [SEL_W-1:0] sel,
    input  logic             rst_req,
    core_switch_if.slave     bus,
    output logic [SEL_W-1:0] active_sel,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(RST_HOLD + 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] target;
    logic [SEL_W-1:0] target_c;
    logic             sel_valid_c;
    logic             blank_c;
    logic             start_done_c;
    logic             drain_done_c;

    function automatic logic [NUM_CORES-1:0] onehot(input logic [SEL_W-1:0] i);
        return NUM_CORES'(1) << i;
    endfunction

    assign sel_valid_c = ({1'b0, sel} < (SEL_W + 1)'(NUM_CORES));
    assign target_c    = sel_valid_c ? sel : target;
    assign blank_c     = !(state == RUN || state == DRAIN);

`ifdef CORE_SWITCH_VBLANK_SYNC_EN
    localparam int unsigned TMO_W = $clog2(SYNC_TIMEOUT + 1);

    video_bus_t       act_c;
    logic             vb_d;
    logic             vb_rise_c;
    logic             tmo_hit_c;
    logic [TMO_W-1:0] tmo;

    assign act_c        = bus.core_in[active_sel];
    assign vb_rise_c    = act_c.vblank & ~vb_d;
    assign tmo_hit_c    = (tmo == TMO_W'(SYNC_TIMEOUT - 1));
    assign start_done_c = vb_rise_c | tmo_hit_c;
    assign drain_done_c = (vb_rise_c & act_c.sd_cs) | tmo_hit_c;

    // Vblank delay and wait timer; the timer is zero whenever START/DRAIN is entered.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            vb_d <= 1'b0;
            tmo  <= '0;
        end else begin
            vb_d <= act_c.vblank;
            if (state == START || state == DRAIN) tmo <= tmo + TMO_W'(1);
            else                                  tmo <= '0;
        end
    end
`else
    assign start_done_c = 1'b1;
    assign drain_done_c = 1'b1;
`endif

    // Lifecycle FSM; enables, resets and busy are registered alongside the state.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state            <= RESET;
            cnt              <= CNT_W'(RST_HOLD);
            active_sel       <= '0;
            target           <= '0;
            bus.core_ce      <= '0;
            bus.core_n_reset <= '0;
            busy             <= 1'b1;
        end else if (rst_req) begin
            state            <= RESET;
            cnt              <= CNT_W'(RST_HOLD);
            bus.core_ce      <= '0;
            bus.core_n_reset <= '0;
            busy             <= 1'b1;
            if (state == RESET) target <= target_c;
        end else begin
            case (state)
                RESET: begin
                    target <= target_c;
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state            <= START;
                        active_sel       <= target_c;
                        bus.core_ce      <= onehot(target_c);
                        bus.core_n_reset <= onehot(target_c);
                    end
                end
                START: begin
                    if (start_done_c) begin
                        state <= RUN;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    if (sel_valid_c && sel != active_sel) begin
                        target <= sel;
                        state  <= DRAIN;
                        busy   <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_done_c) begin
                        state            <= RESET;
                        cnt              <= CNT_W'(RST_HOLD);
                        bus.core_ce      <= '0;
                        bus.core_n_reset <= '0;
                    end
                end
                default: state <= RESET;
            endcase
        end
    end

    core_switch_mux #(
        .NUM_CORES (NUM_CORES),
        .SEL_W     (SEL_W)
    ) u_mux (
        .clk     (clk),
        .n_reset (n_reset),
        .core_in (bus.core_in),
        .idx     (active_sel),
        .blank   (blank_c),
        .vid_out (bus.vid_out)
    );

endmodule

// File: tb/tb_core_switch.sv
// Randomized scoreboard bench for core_switch against a phase-level reference model.
module tb_core_switch;
    import core_switch_pkg::*;

    localparam int unsigned NC      = 3;
    localparam int unsigned SW      = 2;
    localparam int unsigned HOLD    = 16;
    localparam int unsigned TMO     = 100;
    localparam int          N_SEG   = 24;
    localparam int          SEG_LEN = 250;
    localparam int          VW      = $bits(video_bus_t);

    localparam int P_RESET = 0;
    localparam int P_START = 1;
    localparam int P_RUN   = 2;
    localparam int P_DRAIN = 3;

    logic          clk     = 1'b0;
    logic          n_reset = 1'b0;
    logic [SW-1:0] sel     = '0;
    logic          rst_req = 1'b0;
    logic [SW-1:0] active_sel;
    logic          busy;

    core_switch_if #(.NUM_CORES(NC)) bus ();

    core_switch #(
        .NUM_CORES    (NC),
        .SEL_W        (SW),
        .RST_HOLD     (HOLD),
        .SYNC_TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .sel        (sel),
        .rst_req    (rst_req),
        .bus        (bus),
        .active_sel (active_sel),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        video_bus_t    vid;
        logic [NC-1:0] ce;
        logic [NC-1:0] nr;
        logic [SW-1:0] act;
        logic          busy;
    } exp_t;

    exp_t exp_q[$];

    int  n_checks = 0;
    int  n_errors = 0;
    bit  done     = 1'b0;
    int  cyc      = 0;

    // Reference model: which phase we are in and how long we have been there.
    int         m_phase   = P_RESET;
    int         m_quiet   = 0;
    int         m_elapsed = 0;
    int         m_act     = 0;
    int         m_tgt     = 0;
    bit         m_vb_prev = 1'b0;
    video_bus_t m_vid;

    function automatic video_bus_t reset_bus();
        video_bus_t b;
        b        = '0;
        b.hs     = 1'b1;
        b.vs     = 1'b1;
        b.hblank = 1'b1;
        b.vblank = 1'b1;
        b.sd_cs  = 1'b1;
        b.sd_mosi = 1'b1;
        return b;
    endfunction

    function automatic video_bus_t blanked(video_bus_t prev, video_bus_t cur);
        video_bus_t b;
        b        = reset_bus();
        b.hs     = prev.hs;
        b.vs     = prev.vs;
        b.cepix  = cur.cepix;
        return b;
    endfunction

    task automatic enter_reset();
        m_phase = P_RESET;
        m_quiet = 0;
    endtask

    task automatic model_step();
        video_bus_t cur;
        bit         rise;
        bit         sel_ok;
        bit         sync_done;
        exp_t       e;
        cur    = bus.core_in[m_act];
        rise   = cur.vblank && !m_vb_prev;
        sel_ok = int'(sel) < NC;
        m_vid  = (m_phase == P_RUN || m_phase == P_DRAIN) ? cur : blanked(m_vid, cur);
        m_vb_prev = cur.vblank;
        if (rst_req) begin
            if (m_phase == P_RESET && sel_ok) m_tgt = int'(sel);
            enter_reset();
        end else begin
            case (m_phase)
                P_RESET: begin
                    if (sel_ok) m_tgt = int'(sel);
                    if (m_quiet == HOLD) begin
                        m_act     = m_tgt;
                        m_phase   = P_START;
                        m_elapsed = 0;
                    end else begin
                        m_quiet++;
                    end
                end
                P_START: begin
`ifdef CORE_SWITCH_VBLANK_SYNC_EN
                    sync_done = rise || (m_elapsed + 1 == TMO);
`else
                    sync_done = 1'b1;
`endif
                    if (sync_done) m_phase = P_RUN;
                    else           m_elapsed++;
                end
                P_RUN: begin
                    if (sel_ok && int'(sel) != m_act) begin
                        m_tgt     = int'(sel);
                        m_phase   = P_DRAIN;
                        m_elapsed = 0;
                    end
                end
                default: begin
`ifdef CORE_SWITCH_VBLANK_SYNC_EN
                    sync_done = (rise && cur.sd_cs) || (m_elapsed + 1 == TMO);
`else
                    sync_done = 1'b1;
`endif
                    if (sync_done) enter_reset();
                    else           m_elapsed++;
                end
            endcase
        end
        e.vid  = m_vid;
        e.ce   = (m_phase == P_RESET) ? '0 : NC'(1 << m_act);
        e.nr   = e.ce;
        e.act  = SW'(m_act);
        e.busy = (m_phase != P_RUN);
        exp_q.push_back(e);
    endtask

    task automatic drive_cores(input bit freeze, input bit sd_low);
        video_bus_t v;
        for (int c = 0; c < NC; c++) begin
            v        = video_bus_t'(VW'($urandom));
            v.vblank = !freeze && (((cyc + 13 * c) % (60 + 15 * c)) < 8);
            v.sd_cs  = !sd_low;
            bus.core_in[c] = v;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Stimulus: segments of random scenarios; each cycle pushes the predicted post-edge outputs.
    initial begin
        int  scen;
        int  jit;
        bit  freeze;
        bit  sd_low;
        m_vid = reset_bus();
        drive_cores(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        n_reset = 1'b1;
        for (int s = 0; s < N_SEG; s++) begin
            scen = (s == 0) ? 0 : int'($urandom_range(0, 4));
            jit  = int'($urandom_range(0, 30));
            for (int k = 0; k < SEG_LEN; k++) begin
                if (k == 0 && scen != 0) sel = SW'($urandom_range(0, 3));
                if (scen == 1 && k == jit) sel = SW'($urandom_range(0, 3));
                rst_req = (scen == 4 && k >= 5 && k < 45);
                sd_low  = (scen == 2 && k < 150);
                freeze  = (scen == 3 && k < 200);
                drive_cores(freeze, sd_low);
                model_step();
                @(negedge clk);
                cyc++;
            end
        end
        done = 1'b1;
    end

    // Monitor: samples just after each rising edge and compares against the scoreboard.
    int   rel_cyc   = 0;
    int   first_rel = -1;
    int   drops     = 0;
    logic prev_busy = 1'b1;

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!n_reset) begin
            check("reset_vid_out", 32'(bus.vid_out), 32'(reset_bus()));
            check("reset_core_ce", 32'(bus.core_ce), 32'd0);
            check("reset_core_n_reset", 32'(bus.core_n_reset), 32'd0);
            check("reset_active_sel", 32'(active_sel), 32'd0);
            check("reset_busy", 32'(busy), 32'd1);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            rel_cyc++;
            if (first_rel < 0 && bus.core_n_reset != '0) first_rel = rel_cyc;
            if (prev_busy && !busy) drops++;
            prev_busy = busy;
            check("vid_out", 32'(bus.vid_out), 32'(e.vid));
            check("core_ce", 32'(bus.core_ce), 32'(e.ce));
            check("core_n_reset", 32'(bus.core_n_reset), 32'(e.nr));
            check("active_sel", 32'(active_sel), 32'(e.act));
            check("busy", 32'(busy), 32'(e.busy));
        end
        if (done && exp_q.size() == 0) begin
            check("first_release_cycle", 32'(first_rel), 32'(HOLD + 1));
            check("busy_dropped", 32'(drops > 0), 32'd1);
            $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
            $finish;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
